// File: rtl/spi_reg_controller.sv
// spi_reg_controller
// Sits behind an SPI slave byte engine and turns its byte stream into accesses
// on a simple synchronous register bus. A frame's first byte is the command:
// bit7=1 means read, 0 means write, and the low ADDR_W bits hold the start
// address. In a write frame every later byte is written to the bus and the
// address then advances. In a read frame every byte boundary prefetches the
// next register into data_to_send.
//
// Strobe semantics (no ready/back-pressure anywhere):
// - byte_received is a one-cycle strobe. received_data is sampled one cycle
//   later, through byte_stb.
// - reg_we / reg_re are one-cycle strobes. They are never high together.
// - reg_rdata is captured on the clock edge that ends the reg_re cycle.
//   reg_addr still holds the read address during that cycle.
module spi_reg_controller #(
  parameter int unsigned ADDR_W    = 7,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel,
  input  logic              byte_received,
  input  logic [7:0]        received_data,
  output logic [7:0]        data_to_send,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD        = 3'd1,
    ST_WRITE      = 3'd2,
    ST_RD_ISSUE   = 3'd3,
    ST_RD_CAPTURE = 3'd4,
    ST_READ       = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              byte_stb_q, byte_stb_d;
  logic [7:0]        data_to_send_q, data_to_send_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d        = state_q;
    byte_stb_d     = byte_received;
    data_to_send_d = data_to_send_q;
    reg_addr_d     = reg_addr_q;
    reg_wdata_d    = reg_wdata_q;
    reg_we_d       = 1'b0;
    reg_re_d       = 1'b0;

    if (ssel) begin
      // Frame end. Strobes that are not yet issued are dropped, and the
      // address is kept for visibility.
      state_d        = ST_IDLE;
      data_to_send_d = IDLE_BYTE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d        = ST_CMD;
          data_to_send_d = IDLE_BYTE;
        end
        ST_CMD: begin
          if (byte_stb_q) begin
            reg_addr_d = received_data[ADDR_W-1:0];
            state_d    = received_data[7] ? ST_RD_ISSUE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Advance the address in the cycle the write strobe is on the bus.
          if (reg_we_q) begin
            reg_addr_d = reg_addr_q + 1'b1;
          end
          if (byte_stb_q) begin
            reg_wdata_d = received_data;
            reg_we_d    = 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          reg_re_d = 1'b1;
          state_d  = ST_RD_CAPTURE;
        end
        ST_RD_CAPTURE: begin
          data_to_send_d = reg_rdata;
          reg_addr_d     = reg_addr_q + 1'b1;
          state_d        = ST_READ;
        end
        ST_READ: begin
          // The dummy byte's content is irrelevant. Its arrival triggers the
          // prefetch of the next register.
          if (byte_stb_q) begin
            state_d = ST_RD_ISSUE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      byte_stb_q     <= 1'b0;
      data_to_send_q <= IDLE_BYTE;
      reg_addr_q     <= '0;
      reg_wdata_q    <= 8'h00;
      reg_we_q       <= 1'b0;
      reg_re_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_stb_q     <= byte_stb_d;
      data_to_send_q <= data_to_send_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_we_q       <= reg_we_d;
      reg_re_q       <= reg_re_d;
    end
  end

  assign data_to_send = data_to_send_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign reg_we       = reg_we_q;
  assign reg_re       = reg_re_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Testbench for spi_reg_controller. It emulates the SPI slave byte engine
// (strobe plus data, and a reload point where the slave latches data_to_send)
// and a register file that returns regs[reg_addr] combinationally.
module tb_spi_reg_controller;

  localparam int ADDR_W = 7;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd5;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ssel = 1'b1;
  logic              byte_received = 1'b0;
  logic [7:0]        received_data = 8'h00;
  logic [7:0]        data_to_send;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic [2:0]        dbg_state;
  logic              slave_load = 1'b0;

  logic [7:0] regs [128];
  assign reg_rdata = regs[reg_addr];

  spi_reg_controller #(.ADDR_W(ADDR_W), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .ssel(ssel),
    .byte_received(byte_received), .received_data(received_data),
    .data_to_send(data_to_send), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [14:0] exp_we_q[$];   // {addr, wdata}
  logic [6:0]  exp_re_q[$];   // addr
  logic [7:0]  exp_miso_q[$]; // byte the slave loads

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents a bus strobe or the
  // emulated slave reloads. It also owns the register file model.
  initial begin
    logic [14:0] e_we;
    logic [6:0]  e_re;
    logic [7:0]  e_miso;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h10] = 8'h3C;
    regs[7'h11] = 8'hC3;
    forever begin
      @(negedge clk);
      #1;
      if (reg_we && reg_re) check("we_re_overlap", 16'd1, 16'd0);
      if (reg_we) begin
        if (exp_we_q.size() == 0) begin
          check("unexpected_we", {1'b0, reg_addr, reg_wdata}, 16'h7FFF);
        end else begin
          e_we = exp_we_q.pop_front();
          check("write", {1'b0, reg_addr, reg_wdata}, {1'b0, e_we});
        end
        regs[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
        if (exp_re_q.size() == 0) begin
          check("unexpected_re", {9'd0, reg_addr}, 16'hFFFF);
        end else begin
          e_re = exp_re_q.pop_front();
          check("read_addr", {9'd0, reg_addr}, {9'd0, e_re});
        end
      end
      if (slave_load) begin
        if (exp_miso_q.size() == 0) begin
          check("unexpected_load", {8'd0, data_to_send}, 16'hFFFF);
        end else begin
          e_miso = exp_miso_q.pop_front();
          check("miso", {8'd0, data_to_send}, {8'd0, e_miso});
        end
      end
    end
  end

  // Driver tasks
  task automatic pulse_byte(input logic [7:0] b);
    byte_received = 1'b1;
    received_data = b;
    @(negedge clk);
    byte_received = 1'b0;
  endtask

  task automatic pulse_load();
    slave_load = 1'b1;
    @(negedge clk);
    slave_load = 1'b0;
  endtask

  // One full frame: the slave loads a byte at the start and after every
  // byte that is not the last.
  task automatic send_frame(input logic [7:0] fb [4], input int n, input int gap);
    @(negedge clk);
    ssel = 1'b0;
    repeat (2) @(negedge clk);
    pulse_load();
    for (int k = 0; k < n; k++) begin
      repeat (6) @(negedge clk);
      pulse_byte(fb[k]);
      if (k < n - 1) begin
        repeat (5) @(negedge clk);
        pulse_load();
      end
    end
    repeat (8) @(negedge clk);
    ssel = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Directed stimulus
  initial begin
    logic [7:0] fb [4];

    // Reset values
    repeat (2) @(negedge clk);
    #3;
    check("rst_dts", {8'd0, data_to_send}, 16'h0000);
    check("rst_addr", {9'd0, reg_addr}, 16'h0000);
    check("rst_wdata", {8'd0, reg_wdata}, 16'h0000);
    check("rst_strobes", {14'd0, reg_we, reg_re}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write burst: 0x05, 0xAA, 0x55
    fb = '{8'h05, 8'hAA, 8'h55, 8'h00};
    exp_we_q.push_back({7'h05, 8'hAA});
    exp_we_q.push_back({7'h06, 8'h55});
    exp_miso_q.push_back(8'h00);
    exp_miso_q.push_back(8'h00);
    exp_miso_q.push_back(8'h00);
    send_frame(fb, 3, 4);
    check("idle_after_write", {13'd0, dbg_state}, {13'd0, S_IDLE});

    // Read burst: 0x90, 0x00, 0x00
    fb = '{8'h90, 8'h00, 8'h00, 8'h00};
    exp_miso_q.push_back(8'h00);
    exp_miso_q.push_back(8'h3C);
    exp_miso_q.push_back(8'hC3);
    exp_re_q.push_back(7'h10);
    exp_re_q.push_back(7'h11);
    exp_re_q.push_back(7'h12);
    send_frame(fb, 3, 4);
    check("dts_after_read", {8'd0, data_to_send}, 16'h0000);

    // Address wrap
    fb = '{8'h7F, 8'h01, 8'h02, 8'h00};
    exp_we_q.push_back({7'h7F, 8'h01});
    exp_we_q.push_back({7'h00, 8'h02});
    repeat (3) exp_miso_q.push_back(8'h00);
    send_frame(fb, 3, 4);

    // Early abort in the middle of the second byte
    @(negedge clk);
    ssel = 1'b0;
    repeat (2) @(negedge clk);
    pulse_byte(8'h20);
    repeat (10) @(negedge clk);
    #3;
    check("abort_busy_before", {15'd0, busy}, 16'h0001);
    @(negedge clk);
    ssel = 1'b1;
    @(negedge clk);
    #3;
    check("abort_busy", {15'd0, busy}, 16'h0000);
    check("abort_state", {13'd0, dbg_state}, {13'd0, S_IDLE});
    check("abort_dts", {8'd0, data_to_send}, 16'h0000);
    check("abort_addr", {9'd0, reg_addr}, 16'h0020);
    repeat (3) @(negedge clk);

    // Asynchronous reset while in READ
    exp_re_q.push_back(7'h10);
    ssel = 1'b0;
    repeat (2) @(negedge clk);
    pulse_byte(8'h90);
    repeat (5) @(negedge clk);
    #3;
    check("pre_rst_state", {13'd0, dbg_state}, {13'd0, S_READ});
    check("pre_rst_dts", {8'd0, data_to_send}, 16'h003C);
    rst = 1'b1;
    #1;
    check("arst_dts", {8'd0, data_to_send}, 16'h0000);
    check("arst_addr", {9'd0, reg_addr}, 16'h0000);
    check("arst_wdata", {8'd0, reg_wdata}, 16'h0000);
    check("arst_strobes", {14'd0, reg_we, reg_re}, 16'h0000);
    check("arst_busy", {15'd0, busy}, 16'h0000);
    @(negedge clk);
    ssel = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A normal frame after the reset
    fb = '{8'h33, 8'h77, 8'h00, 8'h00};
    exp_we_q.push_back({7'h33, 8'h77});
    repeat (2) exp_miso_q.push_back(8'h00);
    send_frame(fb, 2, 4);

    // Back-to-back frames: a write, ssel high for 2 clk, then a read of the
    // register that was just written
    fb = '{8'h40, 8'h11, 8'h00, 8'h00};
    exp_we_q.push_back({7'h40, 8'h11});
    repeat (2) exp_miso_q.push_back(8'h00);
    send_frame(fb, 2, 1);
    fb = '{8'hC0, 8'h00, 8'h00, 8'h00};
    exp_miso_q.push_back(8'h00);
    exp_miso_q.push_back(8'h11);
    exp_re_q.push_back(7'h40);
    exp_re_q.push_back(7'h41);
    send_frame(fb, 2, 4);

    // Every expected response must have been consumed
    repeat (4) @(negedge clk);
    check("we_q_left", 16'(exp_we_q.size()), 16'd0);
    check("re_q_left", 16'(exp_re_q.size()), 16'd0);
    check("miso_q_left", 16'(exp_miso_q.size()), 16'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
